// File: rtl/j_i2s_tx.sv
// I2S transmitter: write-enabled left/right holding registers, per-frame transfer into the
// frame registers, and MSB-first serialisation on SCK/WS/SD with sample request and underrun flag.
module j_i2s_tx #(
  parameter int WIDTH = 16,
  parameter int DIV   = 2
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic [WIDTH-1:0] ldata,
  input  logic [WIDTH-1:0] rdata,
  input  logic             wr_l,
  input  logic             wr_r,
  input  logic             en,
  input  logic             clr_urun,
  output logic             sck_out,
  output logic             ws_out,
  output logic             sd_out,
  output logic             req,
  output logic             urun
);

  // state | meaning
  // IDLE  | serial outputs held low, counters cleared; en=1 loads the first frame
  // RUN   | prescaler and frame index running; en=0 drops back to IDLE immediately
  typedef enum logic {IDLE, RUN} state_t;

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = $clog2(2 * WIDTH);
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
  localparam logic [FW-1:0] F_LAST    = FW'(2 * WIDTH - 1);
  localparam logic [FW-1:0] WS_FIRST  = FW'(WIDTH - 1);
  localparam logic [FW-1:0] WS_LAST   = FW'(2 * WIDTH - 2);

  state_t state, state_nxt;

  logic [WIDTH-1:0]   hold_l, hold_r, fl, fr;
  logic               fresh_l, fresh_r;
  logic [PW-1:0]      pcnt;
  logic [FW-1:0]      f;
  logic [FW-1:0]      bit_idx;
  logic [2*WIDTH-1:0] frame_word;
  logic               tick, fall, load, underrun, running;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    fall      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
        end else begin
          tick = (pcnt == PCNT_LAST);
          fall = tick && sck_out;
          load = fall && (f == F_LAST);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign running    = (state == RUN) && en;
  assign underrun   = load && !(fresh_l && fresh_r);
  assign frame_word = {fl, fr};
  assign bit_idx    = F_LAST - f;

  // A write coinciding with a load keeps its fresh flag: the load consumed the old value.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      hold_l  <= '0;
      hold_r  <= '0;
      fresh_l <= 1'b0;
      fresh_r <= 1'b0;
    end else begin
      if (wr_l) hold_l <= ldata;
      if (wr_r) hold_r <= rdata;
      fresh_l <= wr_l | (fresh_l & ~load);
      fresh_r <= wr_r | (fresh_r & ~load);
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      fl   <= '0;
      fr   <= '0;
      req  <= 1'b0;
      urun <= 1'b0;
    end else begin
      if (load) begin
        fl <= hold_l;
        fr <= hold_r;
      end
      req <= load;
      if (underrun)      urun <= 1'b1;
      else if (clr_urun) urun <= 1'b0;
    end
  end

  // The last-bit falling edge outputs the right LSB on the same edge that reloads fl/fr.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      pcnt    <= '0;
      f       <= '0;
      sck_out <= 1'b0;
      ws_out  <= 1'b0;
      sd_out  <= 1'b0;
    end else if (running) begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      if (tick) sck_out <= ~sck_out;
      if (fall) begin
        sd_out <= frame_word[bit_idx];
        ws_out <= (f >= WS_FIRST) && (f <= WS_LAST);
        f      <= (f == F_LAST) ? '0 : f + FW'(1);
      end
    end else begin
      pcnt    <= '0;
      f       <= '0;
      sck_out <= 1'b0;
      ws_out  <= 1'b0;
      sd_out  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_j_i2s_tx.sv
// Self-checking bench for j_i2s_tx: DIV=2 and DIV=1 instances against a frame-level reference model.
module tb_j_i2s_tx;

  logic        sys_clk = 1'b0;
  logic        resetl  = 1'b0;
  logic [15:0] ldata   = '0;
  logic [15:0] rdata   = '0;
  logic        wr_l    = 1'b0;
  logic        wr_r    = 1'b0;
  logic        en      = 1'b0;
  logic        clr_urun = 1'b0;

  logic sck0, ws0, sd0, req0, urun0;
  logic sck1, ws1, sd1, req1, urun1;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] hold_l_m, hold_r_m, cur_l, cur_r;
  logic        fresh_l_m, fresh_r_m, urun_m, sd0_m;

  // per-cycle stimulus plan for one frame (index = cycle within frame)
  logic        pl_wl [0:127];
  logic        pl_wr [0:127];
  logic        pl_clr[0:127];
  logic [15:0] pl_lv [0:127];
  logic [15:0] pl_rv [0:127];

  always #5 sys_clk = ~sys_clk;

  j_i2s_tx #(.WIDTH(16), .DIV(2)) dut0 (
    .sys_clk(sys_clk), .resetl(resetl), .ldata(ldata), .rdata(rdata),
    .wr_l(wr_l), .wr_r(wr_r), .en(en), .clr_urun(clr_urun),
    .sck_out(sck0), .ws_out(ws0), .sd_out(sd0), .req(req0), .urun(urun0));

  j_i2s_tx #(.WIDTH(16), .DIV(1)) dut1 (
    .sys_clk(sys_clk), .resetl(resetl), .ldata(ldata), .rdata(rdata),
    .wr_l(wr_l), .wr_r(wr_r), .en(en), .clr_urun(clr_urun),
    .sck_out(sck1), .ws_out(ws1), .sd_out(sd1), .req(req1), .urun(urun1));

  function automatic logic [4:0] obs(input int sel);
    return (sel == 1) ? {sck1, ws1, sd1, req1, urun1} : {sck0, ws0, sd0, req0, urun0};
  endfunction

  task automatic model_reset();
    hold_l_m = '0; hold_r_m = '0; cur_l = '0; cur_r = '0;
    fresh_l_m = 1'b0; fresh_r_m = 1'b0; urun_m = 1'b0; sd0_m = 1'b0;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 128; i++) begin
      pl_wl[i] = 1'b0; pl_wr[i] = 1'b0; pl_clr[i] = 1'b0;
      pl_lv[i] = '0;   pl_rv[i] = '0;
    end
  endtask

  // Frame boundary: frame takes old holding values; missing writes since last load -> underrun.
  task automatic edge_model(input logic ld, input logic wl, input logic wrr,
                            input logic [15:0] nl, input logic [15:0] nr, input logic clr);
    logic set;
    set = 1'b0;
    if (ld) begin
      set   = !(fresh_l_m && fresh_r_m);
      sd0_m = cur_r[0];
      cur_l = hold_l_m;
      cur_r = hold_r_m;
      fresh_l_m = 1'b0;
      fresh_r_m = 1'b0;
    end
    if (set)      urun_m = 1'b1;
    else if (clr) urun_m = 1'b0;
    if (wl)  begin hold_l_m = nl; fresh_l_m = 1'b1; end
    if (wrr) begin hold_r_m = nr; fresh_r_m = 1'b1; end
  endtask

  task automatic write_idle(input logic [15:0] l, input logic [15:0] r);
    wr_l = 1'b1; wr_r = 1'b1; ldata = l; rdata = r;
    @(posedge sys_clk);
    edge_model(1'b0, 1'b1, 1'b1, l, r, 1'b0);
    #1;
    wr_l = 1'b0; wr_r = 1'b0;
  endtask

  task automatic enter_run();
    en = 1'b1;
    @(posedge sys_clk);
    edge_model(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    sd0_m = 1'b0;
    #1;
  endtask

  // Plays one frame from the sample point just after its load edge; stop_t < frame length drops en.
  task automatic run_frame(input int sel, input int div, input int stop_t, input string name);
    int frame_len, ticks, fe, k;
    logic [31:0] word;
    logic [4:0] expv, got;
    frame_len = 64 * div;
    word = {cur_l, cur_r};
    for (int t = 0; t < frame_len; t++) begin
      ticks = t / div;
      fe    = t / (2 * div);
      expv[4] = ticks[0];
      if (fe == 0) begin
        expv[3] = 1'b0;
        expv[2] = sd0_m;
      end else begin
        k = fe - 1;
        expv[3] = (k >= 15) && (k <= 30);
        expv[2] = word[31 - k];
      end
      expv[1] = (t == 0);
      expv[0] = urun_m;
      got = obs(sel);
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL %s t=%0d {sck,ws,sd,req,urun} got %b expected %b", name, t, got, expv);
      end
      if (t == stop_t) begin
        en = 1'b0;
        @(posedge sys_clk);
        #1;
        got = obs(sel);
        checks++;
        if (got !== {4'b0000, urun_m}) begin
          errors++;
          $display("FAIL %s_stop got %b expected %b", name, got, {4'b0000, urun_m});
        end
        return;
      end
      wr_l = pl_wl[t]; ldata = pl_lv[t];
      wr_r = pl_wr[t]; rdata = pl_rv[t];
      clr_urun = pl_clr[t];
      @(posedge sys_clk);
      edge_model(t == frame_len - 1, pl_wl[t], pl_wr[t], pl_lv[t], pl_rv[t], pl_clr[t]);
      #1;
      wr_l = 1'b0; wr_r = 1'b0; clr_urun = 1'b0;
    end
  endtask

  task automatic plan_random_writes(input int frame_len);
    int tl, tr;
    tl = $urandom_range(0, frame_len - 1);
    tr = $urandom_range(0, frame_len - 1);
    pl_wl[tl] = 1'b1; pl_lv[tl] = 16'($urandom);
    pl_wr[tr] = 1'b1; pl_rv[tr] = 16'($urandom);
  endtask

  task automatic do_reset();
    resetl = 1'b0; en = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    resetl = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [9:0] got;
    do_reset();
    repeat (3) begin
      @(posedge sys_clk); #1;
      got = {obs(0), obs(1)};
      checks++;
      if (got !== 10'b0) begin
        errors++; $display("FAIL reset_idle got %b expected %b", got, 10'b0);
      end
    end
    enter_run();
    repeat (30) @(posedge sys_clk);
    #1;
    checks++;
    if ({urun0, urun1} !== 2'b11) begin
      errors++; $display("FAIL entry_underrun got %b expected %b", {urun0, urun1}, 2'b11);
    end
    #2;
    resetl = 1'b0;
    #1;
    got = {obs(0), obs(1)};
    checks++;
    if (got !== 10'b0) begin
      errors++; $display("FAIL reset_async got %b expected %b", got, 10'b0);
    end
    @(posedge sys_clk); #1;
    en = 1'b0; resetl = 1'b1;
    model_reset();
    repeat (4) begin
      @(posedge sys_clk); #1;
      got = {obs(0), obs(1)};
      checks++;
      if (got !== 10'b0) begin
        errors++; $display("FAIL reset_release got %b expected %b", got, 10'b0);
      end
    end
  endtask

  task automatic test_frame();
    write_idle(16'hA5F0, 16'h0FF1);
    enter_run();
    clear_plan();
    run_frame(0, 2, 9999, "frame1");
  endtask

  task automatic test_underrun();
    checks++;
    if (urun0 !== 1'b1) begin
      errors++; $display("FAIL underrun_set got %b expected %b", urun0, 1'b1);
    end
    clear_plan();
    pl_clr[10] = 1'b1;
    plan_random_writes(128);
    run_frame(0, 2, 9999, "frame2_repeat");
  endtask

  task automatic test_load_collision();
    clear_plan();
    pl_wl[40] = 1'b1; pl_lv[40] = 16'($urandom);
    pl_wr[70] = 1'b1; pl_rv[70] = 16'($urandom);
    pl_wl[127] = 1'b1; pl_lv[127] = 16'h1234;
    pl_wr[127] = 1'b1; pl_rv[127] = 16'($urandom);
    run_frame(0, 2, 9999, "collide_f3");
    clear_plan();
    run_frame(0, 2, 9999, "collide_old");
    checks++;
    if (cur_l !== 16'h1234 || urun0 !== 1'b0) begin
      errors++; $display("FAIL collide_new got l=%h urun=%b expected l=1234 urun=0", cur_l, urun0);
    end
    clear_plan();
    plan_random_writes(128);
    run_frame(0, 2, 9999, "collide_new");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      clear_plan();
      plan_random_writes(128);
      run_frame(0, 2, 9999, "b2b");
    end
  endtask

  task automatic test_disable();
    logic [4:0] got;
    clear_plan();
    plan_random_writes(128);
    run_frame(0, 2, 38, "disable_f9");
    repeat (5) begin
      @(posedge sys_clk); #1;
      got = obs(0);
      checks++;
      if (got !== {4'b0000, urun_m}) begin
        errors++; $display("FAIL disable_idle got %b expected %b", got, {4'b0000, urun_m});
      end
    end
    write_idle(16'($urandom), 16'($urandom));
    enter_run();
    clear_plan();
    plan_random_writes(128);
    run_frame(0, 2, 9999, "restart");
    clear_plan();
    run_frame(0, 2, 5, "restart_exit");
  endtask

  task automatic test_div1();
    do_reset();
    write_idle(16'hA5F0, 16'h0FF1);
    enter_run();
    clear_plan();
    plan_random_writes(64);
    run_frame(1, 1, 9999, "div1_f1");
    clear_plan();
    plan_random_writes(64);
    run_frame(1, 1, 9999, "div1_f2");
    clear_plan();
    run_frame(1, 1, 3, "div1_exit");
  endtask

  initial begin
    model_reset();
    clear_plan();
    #2;
    test_reset();
    test_frame();
    test_underrun();
    test_load_collision();
    test_back_to_back();
    test_disable();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
